complement_unit_scheduler: RTL and testbench
============================================

// Module: complement_unit_scheduler
// PURPOSE
//  Shares one full_adder_4bits_XOR complement unit between REQ_NUM requesters in the calculator datapath.
//  Round-robin arbitration, registered operand issue, fixed one-cycle complement1_sel pulse, result capture.
//  One-hot response return; a watchdog converts a missing finish into an error response.
//  Sits between the calculator control FSM/operand paths and the single complement unit instance.
// PARAMETERS
//  REQ_NUM  4  number of requesters (2..8)
//  DATA_W   4  operand/result width; must equal complement unit width
//  TIMEOUT  8  max WAIT cycles for cu_finish before error response (>=4)
// PORTS
//  clk          in   1               system clock, rising edge
//  rst          in   1               asynchronous, active-low reset
//  req_valid    in   REQ_NUM         per-requester request level
//  req_a        in   REQ_NUM*DATA_W  operand a, requester i at [i*DATA_W +: DATA_W]
//  req_b        in   REQ_NUM*DATA_W  operand b, same packing
//  req_ci       in   REQ_NUM         carry-in per requester
//  gnt          out  REQ_NUM         one-hot owner of the unit, ISSUE..RESP
//  resp_valid   out  REQ_NUM         one-hot, 1-cycle response strobe
//  resp_sum     out  DATA_W          result, valid with resp_valid
//  resp_err     out  1               timeout flag, valid with resp_valid
//  busy         out  1               FSM not IDLE
//  cu_sel       out  1               to unit complement1_sel, 1-cycle pulse
//  cu_a/cu_b    out  DATA_W each     to unit a/b
//  cu_ci        out  1               to unit ci
//  cu_sum       in   DATA_W          from unit sum
//  cu_finish    in   1               from unit complement1_finish (level)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer = REQ_NUM-1 (requester 0 wins first), timer 0.
//  All outputs registered. FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  IDLE: any req_valid -> winner = first set bit searching from ptr+1 cyclically.
//   Latch idx, gnt, cu_a/cu_b/cu_ci from winner -> ISSUE.
//  ISSUE: cu_sel=1 for exactly this cycle -> WAIT, timer cleared.
//  WAIT: cu_sel=0; cu_a/b/ci held (unit samples operands 2 cycles after sel).
//   cu_finish high -> latch resp_sum=cu_sum, err=0 -> RESP.
//   Else timer==TIMEOUT-1 -> resp_sum=0, err=1 -> RESP.
//  cu_finish outside WAIT ignored; unit raises finish spontaneously after reset and holds it high.
//   Never treat a stale finish as completion.
//  RESP: resp_valid[idx]=1, resp_err driven, one cycle. ptr<=idx, gnt cleared -> IDLE.
//  Nominal latency: req sampled in IDLE cycle N -> cu_sel N+1 -> finish N+4 -> resp_valid N+5.
//   Back-to-back throughput is one op per 6 cycles.
//  Requester holds req_valid until its resp_valid. req_valid still high the cycle after
//   resp is a new request, arbitrated against others.
//  Request dropped mid-op: op completes, response still issued, no abort.
//  Operand change after grant: ignored (latched copy used).
//  resp_sum/resp_err hold last value between strobes.
//  Async reset asserted mid-op: immediate IDLE, cu_sel/gnt/resp_valid low, response lost.
//   Requester re-requests.
// STRUCTURE
//  calc_defs.vh: state encodings (ST_IDLE..ST_RESP, 2 bits), default DATA_W/TIMEOUT constants.
//  Sub-module rr_arbiter #(REQ_NUM): req vector + ptr -> one-hot grant + index; combinational.
//  Top: FSM, operand/result registers, watchdog counter ($clog2(TIMEOUT) bits).
// TESTING (bench instantiates the real complement unit; model: a[3]==0 ? a : {1,(~a[2:0]+b[2:0]+ci)[2:0]})
//  Single req0 a=4'hA b=0 ci=0 -> cu_sel 1 cycle, resp_valid=4'b0001 five cycles later, sum=4'hD, err=0.
//  req0 a=4'h5 b=4'h3 ci=1 -> resp_sum=4'h5 (positive passthrough), err=0.
//  All 4 req held high -> grants 0,1,2,3,0 in order, one resp per 6 cycles, no requester starved.
//  Finish stub held high from reset, req1 issued -> completion only on finish seen in WAIT, not before.
//  Finish stub never raised -> resp_valid after TIMEOUT WAIT cycles, err=1, sum=0, next req served.
//  rst low during WAIT -> all outputs 0 asynchronously; after release req2 completes normally.

Source files
------------

// File: rtl/complement_unit_scheduler_pkg.sv
// Shared types and default sizing for the complement unit scheduler.
package complement_unit_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam int DEF_REQ_NUM = 4;
    localparam int DEF_DATA_W  = 4;
    localparam int DEF_TIMEOUT = 8;

endpackage

// File: rtl/complement_unit_scheduler_rr_arbiter.sv
// Round-robin pick: first set request after ptr, cyclically.
// Purely combinational, one-hot grant plus binary index.
module complement_unit_scheduler_rr_arbiter #(
    parameter int REQ_NUM = 4,
    localparam int IW = $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [REQ_NUM-1:0] gnt,
    output logic [IW-1:0]      idx
);

    logic          found;
    logic [IW-1:0] cand;

    // scan ptr+1 .. ptr+REQ_NUM, first hit wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= REQ_NUM; k++) begin
            cand = IW'((int'(ptr) + k) % REQ_NUM);
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/complement_unit_scheduler.sv
// Shares one complement unit between REQ_NUM requesters:
// round-robin grant, registered issue, one-cycle sel, watchdog.
module complement_unit_scheduler
    import complement_unit_scheduler_pkg::*;
#(
    parameter int REQ_NUM = DEF_REQ_NUM,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REQ_NUM-1:0]        req_valid,
    input  logic [REQ_NUM*DATA_W-1:0] req_a,
    input  logic [REQ_NUM*DATA_W-1:0] req_b,
    input  logic [REQ_NUM-1:0]        req_ci,
    output logic [REQ_NUM-1:0]        gnt,
    output logic [REQ_NUM-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_sum,
    output logic                      resp_err,
    output logic                      busy,
    output logic                      cu_sel,
    output logic [DATA_W-1:0]         cu_a,
    output logic [DATA_W-1:0]         cu_b,
    output logic                      cu_ci,
    input  logic [DATA_W-1:0]         cu_sum,
    input  logic                      cu_finish
);

    localparam int IW = $clog2(REQ_NUM);
    localparam int TW = $clog2(TIMEOUT);

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       ptr_q, ptr_d;
    logic [REQ_NUM-1:0]  gnt_q, gnt_d;
    logic [REQ_NUM-1:0]  resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0]   resp_sum_q, resp_sum_d;
    logic                resp_err_q, resp_err_d;
    logic                busy_q, busy_d;
    logic                cu_sel_q, cu_sel_d;
    logic [DATA_W-1:0]   cu_a_q, cu_a_d;
    logic [DATA_W-1:0]   cu_b_q, cu_b_d;
    logic                cu_ci_q, cu_ci_d;
    logic [TW-1:0]       timer_q, timer_d;
    logic                armed_q, armed_d;

    logic [REQ_NUM-1:0]  arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic [DATA_W-1:0]   a_arr [REQ_NUM];
    logic [DATA_W-1:0]   b_arr [REQ_NUM];

    for (genvar i = 0; i < REQ_NUM; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*DATA_W +: DATA_W];
        assign b_arr[i] = req_b[i*DATA_W +: DATA_W];
    end

    complement_unit_scheduler_rr_arbiter #(
        .REQ_NUM (REQ_NUM)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    // next-state and registered-output computation
    // armed: finish must be seen low inside WAIT before a high
    // counts, so the unit's stale post-reset/previous finish is ignored
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        resp_valid_d = '0;
        resp_sum_d   = resp_sum_q;
        resp_err_d   = resp_err_q;
        cu_sel_d     = 1'b0;
        cu_a_d       = cu_a_q;
        cu_b_d       = cu_b_q;
        cu_ci_d      = cu_ci_q;
        timer_d      = timer_q;
        armed_d      = armed_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|req_valid) begin
                    idx_d    = arb_idx;
                    gnt_d    = arb_gnt;
                    cu_a_d   = a_arr[arb_idx];
                    cu_b_d   = b_arr[arb_idx];
                    cu_ci_d  = req_ci[arb_idx];
                    cu_sel_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                armed_d = 1'b0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cu_finish && armed_q) begin
                    resp_sum_d   = cu_sum;
                    resp_err_d   = 1'b0;
                    resp_valid_d = gnt_q;
                    state_d      = ST_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    resp_sum_d   = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = gnt_q;
                    state_d      = ST_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                    if (!cu_finish) begin
                        armed_d = 1'b1;
                    end
                end
            end
            ST_RESP: begin
                ptr_d   = idx_q;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            ptr_q        <= IW'(REQ_NUM - 1);
            gnt_q        <= '0;
            resp_valid_q <= '0;
            resp_sum_q   <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            cu_sel_q     <= 1'b0;
            cu_a_q       <= '0;
            cu_b_q       <= '0;
            cu_ci_q      <= 1'b0;
            timer_q      <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            resp_valid_q <= resp_valid_d;
            resp_sum_q   <= resp_sum_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
            cu_sel_q     <= cu_sel_d;
            cu_a_q       <= cu_a_d;
            cu_b_q       <= cu_b_d;
            cu_ci_q      <= cu_ci_d;
            timer_q      <= timer_d;
            armed_q      <= armed_d;
        end
    end

    assign gnt        = gnt_q;
    assign resp_valid = resp_valid_q;
    assign resp_sum   = resp_sum_q;
    assign resp_err   = resp_err_q;
    assign busy       = busy_q;
    assign cu_sel     = cu_sel_q;
    assign cu_a       = cu_a_q;
    assign cu_b       = cu_b_q;
    assign cu_ci      = cu_ci_q;

endmodule

// File: tb/tb_complement_unit_scheduler.sv
// Directed bench for complement_unit_scheduler with a behavioural
// complement unit model and a switchable finish/sum stub.
module tb_complement_unit_scheduler;

    localparam int RN = 4;
    localparam int DW = 4;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [RN-1:0]   req_valid;
    logic [RN*DW-1:0] req_a;
    logic [RN*DW-1:0] req_b;
    logic [RN-1:0]   req_ci;
    logic [RN-1:0]   gnt;
    logic [RN-1:0]   resp_valid;
    logic [DW-1:0]   resp_sum;
    logic            resp_err;
    logic            busy;
    logic            cu_sel;
    logic [DW-1:0]   cu_a;
    logic [DW-1:0]   cu_b;
    logic            cu_ci;
    logic [DW-1:0]   cu_sum;
    logic            cu_finish;

    logic            fin_mode;
    logic            stub_fin;
    logic [DW-1:0]   stub_sum;
    logic            m_fin;
    logic [1:0]      m_cnt;
    logic [DW-1:0]   m_sum;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    complement_unit_scheduler #(
        .REQ_NUM (RN),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ci     (req_ci),
        .gnt        (gnt),
        .resp_valid (resp_valid),
        .resp_sum   (resp_sum),
        .resp_err   (resp_err),
        .busy       (busy),
        .cu_sel     (cu_sel),
        .cu_a       (cu_a),
        .cu_b       (cu_b),
        .cu_ci      (cu_ci),
        .cu_sum     (cu_sum),
        .cu_finish  (cu_finish)
    );

    function automatic logic [3:0] unit_calc(
        input logic [3:0] a, input logic [3:0] b, input logic ci);
        logic [2:0] t;
        t = ~a[2:0] + b[2:0] + {2'b00, ci};
        return a[3] ? {1'b1, t} : a;
    endfunction

    // complement unit model: finish high after reset, drops after sel,
    // rises again with the result three edges after sel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_fin <= 1'b1;
            m_cnt <= 2'd0;
            m_sum <= '0;
        end else if (cu_sel) begin
            m_fin <= 1'b0;
            m_cnt <= 2'd1;
        end else if (m_cnt == 2'd1) begin
            m_cnt <= 2'd2;
        end else if (m_cnt == 2'd2) begin
            m_fin <= 1'b1;
            m_sum <= unit_calc(cu_a, cu_b, cu_ci);
            m_cnt <= 2'd0;
        end
    end

    assign cu_finish = fin_mode ? stub_fin : m_fin;
    assign cu_sum    = fin_mode ? stub_sum : m_sum;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // issue one request from a negedge, change its operands after the
    // grant, and check latency, sel pulse count and the response
    task automatic run_op(input int r, input logic [3:0] a,
                          input logic [3:0] b, input logic ci,
                          input int exp_lat, input logic [3:0] exp_sum,
                          input logic exp_err, input string tag);
        int lat;
        int sels;
        lat  = 0;
        sels = 0;
        req_a[r*DW +: DW] = a;
        req_b[r*DW +: DW] = b;
        req_ci[r]         = ci;
        req_valid[r]      = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (cu_sel) sels++;
            if (k == 1) begin
                req_a[r*DW +: DW] = ~a;
                req_b[r*DW +: DW] = ~b;
            end
            if (resp_valid != '0) begin
                lat = k;
                break;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_sels"}, sels, 1);
        chk({tag, "_rv"}, {28'd0, resp_valid}, 32'(1 << r));
        chk({tag, "_sum"}, {28'd0, resp_sum}, {28'd0, exp_sum});
        chk({tag, "_err"}, {31'd0, resp_err}, {31'd0, exp_err});
        req_valid[r] = 1'b0;
        @(negedge clk);
        chk({tag, "_rv_off"}, {28'd0, resp_valid}, 32'd0);
        chk({tag, "_idle"}, {27'd0, busy, gnt}, 32'd0);
        chk({tag, "_hold"}, {28'd0, resp_sum}, {28'd0, exp_sum});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [3:0] rr_ord [5];
        logic [3:0] rr_sum [5];
        int gap;
        int prem;
        rr_ord = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0};
        rr_sum = '{4'hF, 4'h3, 4'hE, 4'h8, 4'hF};
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_ci    = '0;
        fin_mode  = 1'b0;
        stub_fin  = 1'b0;
        stub_sum  = '0;

        repeat (2) @(negedge clk);
        chk("rst_gnt", {28'd0, gnt}, 32'd0);
        chk("rst_rv", {28'd0, resp_valid}, 32'd0);
        chk("rst_sum_err", {27'd0, resp_err, resp_sum}, 32'd0);
        chk("rst_busy_sel", {30'd0, busy, cu_sel}, 32'd0);
        chk("rst_cu_ops", {23'd0, cu_ci, cu_b, cu_a}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // all four requesters held: strict rotation starting at 0
        req_a     = {4'hF, 4'hC, 4'h3, 4'h9};
        req_b     = {4'h7, 4'h2, 4'h0, 4'h1};
        req_ci    = 4'b1100;
        req_valid = 4'hF;
        for (int n = 0; n < 5; n++) begin
            gap = 0;
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (resp_valid != '0) begin
                    gap = k;
                    break;
                end
            end
            chk($sformatf("rr%0d_rv", n), {28'd0, resp_valid},
                32'(1 << rr_ord[n]));
            chk($sformatf("rr%0d_gap", n), gap, (n == 0) ? 5 : 6);
            chk($sformatf("rr%0d_sum", n), {28'd0, resp_sum},
                {28'd0, rr_sum[n]});
        end
        req_valid = '0;
        req_ci    = '0;
        @(negedge clk);
        chk("rr_idle", {31'd0, busy}, 32'd0);
        @(negedge clk);

        run_op(0, 4'hA, 4'h0, 1'b0, 5, 4'hD, 1'b0, "neg_a");
        run_op(0, 4'h5, 4'h3, 1'b1, 5, 4'h5, 1'b0, "pos_pass");

        // finish stuck high: only a low-then-high inside WAIT completes
        fin_mode     = 1'b1;
        stub_fin     = 1'b1;
        stub_sum     = 4'h6;
        req_a[7:4]   = 4'h2;
        req_valid[1] = 1'b1;
        prem = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (resp_valid != '0) prem++;
        end
        chk("stale_early", prem, 0);
        stub_fin = 1'b0;
        @(negedge clk);
        chk("stale_low", {28'd0, resp_valid}, 32'd0);
        stub_fin = 1'b1;
        @(negedge clk);
        chk("stale_rv", {28'd0, resp_valid}, 32'h2);
        chk("stale_sum", {28'd0, resp_sum}, 32'h6);
        chk("stale_err", {31'd0, resp_err}, 32'd0);
        req_valid[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // finish never rises: watchdog error response
        stub_fin = 1'b0;
        run_op(3, 4'h1, 4'h2, 1'b0, 10, 4'h0, 1'b1, "tmo");
        fin_mode = 1'b0;
        run_op(0, 4'h9, 4'h1, 1'b0, 5, 4'hF, 1'b0, "post_tmo");

        // async reset while in WAIT
        req_a[11:8]  = 4'h9;
        req_b[11:8]  = 4'h1;
        req_ci[2]    = 1'b0;
        req_valid[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_gnt_rv", {24'd0, gnt, resp_valid}, 32'd0);
        chk("arst_busy_sel", {30'd0, busy, cu_sel}, 32'd0);
        chk("arst_cu_a", {28'd0, cu_a}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_op(2, 4'h9, 4'h1, 1'b0, 5, 4'hF, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
